// File: rtl/farm_sensor_conditioner.sv
// Conditions the raw farm-road vehicle loop into the controller's C request.
// Synchronise, debounce, latch a service request, count arrivals, flag a stuck loop.
module farm_sensor_conditioner #(
  parameter int DEBOUNCE = 4,
  parameter int STUCK    = 64,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_raw,
  input  logic             FG,
  input  logic             count_clr,
  output logic             C,
  output logic             veh_pulse,
  output logic [CNT_W-1:0] car_count,
  output logic             fault
);
  localparam int DC_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int SC_W = $clog2(STUCK + 1);
  localparam logic [DC_W-1:0]  DC_MAX  = DC_W'(DEBOUNCE - 1);
  localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STUCK);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_q, s1_d, s2_q, s2_d;
  logic             deb_q, deb_d, deb_dly_q, deb_dly_d;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic             req_q, req_d;
  logic             veh_pulse_q, veh_pulse_d;
  logic [SC_W-1:0]  scnt_q, scnt_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] car_count_q, car_count_d;

  always_comb begin
    s1_d        = sensor_raw;
    s2_d        = s1_q;
    deb_d       = deb_q;
    dcnt_d      = '0;
    deb_dly_d   = deb_q;
    veh_pulse_d = deb_q & ~deb_dly_q;
    req_d       = req_q;
    scnt_d      = '0;
    fault_d     = 1'b0;
    car_count_d = car_count_q;

    // A new level is adopted only after DEBOUNCE consecutive disagreeing samples.
    if (s2_q != deb_q) begin
      if (dcnt_q == DC_MAX) deb_d = s2_q;
      else                  dcnt_d = dcnt_q + DC_W'(1);
    end

    if (veh_pulse_q) req_d = 1'b1;
    else if (FG)     req_d = 1'b0;

    if (deb_q) begin
      scnt_d  = (scnt_q == SC_MAX) ? SC_MAX : scnt_q + SC_W'(1);
      fault_d = fault_q | (scnt_d == SC_MAX);
    end

    if (count_clr)                                car_count_d = '0;
    else if (veh_pulse_q && car_count_q != CNT_MAX) car_count_d = car_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      deb_q       <= 1'b0;
      deb_dly_q   <= 1'b0;
      dcnt_q      <= '0;
      req_q       <= 1'b0;
      veh_pulse_q <= 1'b0;
      scnt_q      <= '0;
      fault_q     <= 1'b0;
      car_count_q <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      deb_q       <= deb_d;
      deb_dly_q   <= deb_dly_d;
      dcnt_q      <= dcnt_d;
      req_q       <= req_d;
      veh_pulse_q <= veh_pulse_d;
      scnt_q      <= scnt_d;
      fault_q     <= fault_d;
      car_count_q <= car_count_d;
    end
  end

  // A stuck loop keeps only its latched request, so it is served once.
  assign C         = fault_q ? req_q : (deb_q | req_q);
  assign veh_pulse = veh_pulse_q;
  assign car_count = car_count_q;
  assign fault     = fault_q;
endmodule

// File: tb/tb_farm_sensor_conditioner.sv
// Randomised and directed bench for farm_sensor_conditioner (DEBOUNCE=4, STUCK=16, CNT_W=4).
module tb_farm_sensor_conditioner;
  localparam int DB = 4;
  localparam int ST = 16;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sensor_raw = 1'b0;
  logic          FG = 1'b0;
  logic          count_clr = 1'b0;
  logic          C, veh_pulse, fault;
  logic [CW-1:0] car_count;

  int n_tests = 0;
  int n_fail  = 0;

  farm_sensor_conditioner #(.DEBOUNCE(DB), .STUCK(ST), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .sensor_raw(sensor_raw), .FG(FG), .count_clr(count_clr),
    .C(C), .veh_pulse(veh_pulse), .car_count(car_count), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model: run lengths and plain integers, updated once per rising edge.
  int m_s1, m_s2, m_deb, m_deb_prev, m_disagree, m_pulse, m_req, m_hi_run, m_fault, m_cnt;
  int m_c;
  initial begin
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_prev = 0; m_disagree = 0;
    m_pulse = 0; m_req = 0; m_hi_run = 0; m_fault = 0; m_cnt = 0;
  end

  always @(posedge clk) begin
    int n_deb, n_dis, n_hi, n_fault, n_req, n_cnt, n_pulse;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_prev = 0; m_disagree = 0;
      m_pulse = 0; m_req = 0; m_hi_run = 0; m_fault = 0; m_cnt = 0;
    end else begin
      n_deb = m_deb;
      n_dis = (m_s2 != m_deb) ? m_disagree + 1 : 0;
      if (n_dis >= DB) begin n_deb = m_s2; n_dis = 0; end
      n_pulse = (m_deb == 1 && m_deb_prev == 0) ? 1 : 0;
      n_req   = m_pulse ? 1 : (FG ? 0 : m_req);
      n_hi    = m_deb ? ((m_hi_run + 1 > ST) ? ST : m_hi_run + 1) : 0;
      n_fault = m_deb ? ((m_fault || n_hi >= ST) ? 1 : 0) : 0;
      n_cnt   = count_clr ? 0 : ((m_pulse && m_cnt < CMAX) ? m_cnt + 1 : m_cnt);
      m_deb_prev = m_deb;
      m_s2 = m_s1; m_s1 = int'(sensor_raw);
      m_deb = n_deb; m_disagree = n_dis; m_pulse = n_pulse; m_req = n_req;
      m_hi_run = n_hi; m_fault = n_fault; m_cnt = n_cnt;
    end
  end
  assign m_c = m_fault ? m_req : ((m_deb | m_req) != 0 ? 1 : 0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sensor_raw = 1'b0; FG = 1'b0; count_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    n_tests++; if (C !== 1'b0) begin n_fail++; $display("FAIL reset_C got %b want 0", C); end
    n_tests++; if (veh_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %b want 0", veh_pulse); end
    n_tests++; if (car_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", car_count); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault); end
    repeat (4) step();
  endtask

  task automatic test_arrival();
    sensor_raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 5) begin n_tests++; if (C !== 1'b0) begin n_fail++; $display("FAIL arr_C_early got %b want 0", C); end end
      if (k == 6) begin
        n_tests++; if (C !== 1'b1) begin n_fail++; $display("FAIL arr_C_latency got %b want 1", C); end
        n_tests++; if (veh_pulse !== 1'b0) begin n_fail++; $display("FAIL arr_pulse_early got %b want 0", veh_pulse); end
      end
      if (k == 7) begin n_tests++; if (veh_pulse !== 1'b1) begin n_fail++; $display("FAIL arr_pulse got %b want 1", veh_pulse); end end
      if (k == 8) begin
        n_tests++; if (veh_pulse !== 1'b0) begin n_fail++; $display("FAIL arr_pulse_width got %b want 0", veh_pulse); end
        n_tests++; if (car_count !== 4'd1) begin n_fail++; $display("FAIL arr_count got %0d want 1", car_count); end
      end
    end
    sensor_raw = 1'b0; FG = 1'b1;
    repeat (12) step();
    FG = 1'b0;
  endtask

  task automatic test_glitch();
    sensor_raw = 1'b1;
    repeat (3) step();
    sensor_raw = 1'b0;
    for (int k = 0; k < 12; k++) begin
      n_tests++;
      if (C !== 1'b0 || veh_pulse !== 1'b0) begin
        n_fail++; $display("FAIL glitch_quiet cyc %0d got C=%b pulse=%b want 0 0", k, C, veh_pulse);
      end
      step();
    end
    n_tests++; if (car_count !== 4'd1) begin n_fail++; $display("FAIL glitch_count got %0d want 1", car_count); end
  endtask

  task automatic test_req_hold();
    FG = 1'b0; sensor_raw = 1'b1;
    repeat (10) step();
    sensor_raw = 1'b0;
    repeat (12) step();
    n_tests++; if (C !== 1'b1) begin n_fail++; $display("FAIL req_hold got %b want 1", C); end
    FG = 1'b1;
    step();
    n_tests++; if (C !== 1'b0) begin n_fail++; $display("FAIL req_clear got %b want 0", C); end
    FG = 1'b0;
  endtask

  task automatic test_stuck();
    bit seen;
    sensor_raw = 1'b1;
    repeat (10) step();
    FG = 1'b1; step(); FG = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      n_tests++;
      if (int'(fault) != m_fault) begin n_fail++; $display("FAIL stuck_rise cyc %0d got %b want %0d", k, fault, m_fault); end
      seen = fault;
    end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL stuck_timeout got fault=%b want 1", fault); end
    n_tests++; if (C !== 1'b0) begin n_fail++; $display("FAIL stuck_C got %b want 0", C); end
    sensor_raw = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      n_tests++;
      if (int'(fault) != m_fault) begin n_fail++; $display("FAIL stuck_fall cyc %0d got %b want %0d", k, fault, m_fault); end
      seen = !fault;
    end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL stuck_clear got %b want 0", fault); end
    repeat (4) step();
  endtask

  task automatic test_saturation();
    bit seen;
    count_clr = 1'b1; step(); count_clr = 1'b0;
    n_tests++; if (car_count !== 4'd0) begin n_fail++; $display("FAIL sat_clr got %0d want 0", car_count); end
    for (int i = 0; i < 20; i++) begin
      sensor_raw = 1'b1; repeat (8) step();
      sensor_raw = 1'b0; repeat (8) step();
    end
    n_tests++; if (int'(car_count) != CMAX) begin n_fail++; $display("FAIL sat_count got %0d want %0d", car_count, CMAX); end
    count_clr = 1'b1; step(); count_clr = 1'b0;
    sensor_raw = 1'b1; repeat (8) step();
    sensor_raw = 1'b0; repeat (8) step();
    n_tests++; if (car_count !== 4'd1) begin n_fail++; $display("FAIL sat_one got %0d want 1", car_count); end
    sensor_raw = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin step(); seen = veh_pulse; end
    n_tests++; if (!seen) begin n_fail++; $display("FAIL sat_pulse_timeout got 0 want 1"); end
    count_clr = 1'b1; step(); count_clr = 1'b0;
    n_tests++; if (car_count !== 4'd0) begin n_fail++; $display("FAIL clr_wins got %0d want 0", car_count); end
    sensor_raw = 1'b0; repeat (8) step();
  endtask

  task automatic test_reset_mid();
    FG = 1'b0; sensor_raw = 1'b1;
    repeat (30) step();
    n_tests++; if (fault !== 1'b1 || C !== 1'b1) begin n_fail++; $display("FAIL mid_pre got fault=%b C=%b want 1 1", fault, C); end
    sensor_raw = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    n_tests++;
    if (C !== 1'b0 || veh_pulse !== 1'b0 || fault !== 1'b0 || car_count !== 4'd0) begin
      n_fail++; $display("FAIL mid_reset got C=%b pulse=%b fault=%b cnt=%0d want 0 0 0 0", C, veh_pulse, fault, car_count);
    end
    repeat (2) step();
  endtask

  task automatic test_random();
    int run = 0;
    bit prev_pulse = 1'b0;
    for (int k = 0; k < 512; k++) begin
      if (run == 0) begin sensor_raw = 1'($urandom % 2); run = $urandom_range(1, 12); end
      run--;
      FG = ($urandom_range(0, 7) == 0);
      count_clr = ($urandom_range(0, 31) == 0);
      step();
      n_tests++;
      if (int'(C) != m_c || int'(veh_pulse) != m_pulse || int'(car_count) != m_cnt || int'(fault) != m_fault) begin
        n_fail++;
        $display("FAIL rand cyc %0d got C=%b p=%b cnt=%0d f=%b want %0d %0d %0d %0d",
                 k, C, veh_pulse, car_count, fault, m_c, m_pulse, m_cnt, m_fault);
      end
      n_tests++;
      if (prev_pulse && veh_pulse) begin n_fail++; $display("FAIL rand_double_pulse cyc %0d got 1 want 0", k); end
      prev_pulse = veh_pulse;
    end
    FG = 1'b0; count_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arrival();
    test_glitch();
    test_req_hold();
    test_stuck();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
